// File: rtl/maze_parameters.sv
// ============================================================================
// Module   : maze_parameters (package)
// Purpose  : Shared maze geometry defaults, FSM state encoding, direction
//            encoding and the button-priority helper for the maze movement
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_parameters;

  localparam int MAZE_W  = 10;
  localparam int MAZE_H  = 10;
  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CHECK      = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_WIN        = 2'd3
  } state_t;

  // Direction codes double as the bit index of each button in the edge vector.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Lowest index wins, giving up > down > left > right.
  function automatic dir_t pick_dir(input logic [3:0] edges);
    dir_t d;
    if (edges[0])      d = DIR_UP;
    else if (edges[1]) d = DIR_DOWN;
    else if (edges[2]) d = DIR_LEFT;
    else               d = DIR_RIGHT;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge_detect.sv
// ============================================================================
// Module   : btn_edge_detect
// Purpose  : Registered rising-edge detector for level-sensitive buttons.
//            The history register resets to all-ones so a button held
//            through reset is not reported as a new press.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous, active-low
//            btn      - WIDTH synchronous button levels
//            btn_edge - WIDTH rising-edge flags (btn & ~previous btn)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_edge
);

  logic [WIDTH-1:0] r_btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_q <= '1;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign btn_edge = btn & ~r_btn_q;

endmodule

`default_nettype wire

// File: rtl/maze_move_ctrl.sv
// ============================================================================
// Module   : maze_move_ctrl
// Purpose  : Sequences player movement through a bitmap maze. One button
//            edge is accepted per move, the target cell is checked against
//            the maze bounds and walls, and the new position is committed
//            only on a frame boundary so the display never tears.
// Ports    : clk         - clock, rising edge
//            reset       - asynchronous, active-low
//            maze        - MAZE_W*MAZE_H wall bitmap, bit y*MAZE_W+x, 1 = wall
//            btn_up/down/left/right - debounced level buttons
//            frame_start - one-cycle pulse at start of vertical blanking
//            restart     - one-cycle pulse returning the game to start
//            player_pos  - {x, y} current position
//            player_end  - {END_X, END_Y} goal position (constant)
//            win         - high from goal commit until restart/reset
//            move_count  - committed move count, saturating at 16'hFFFF
//            bump        - one-cycle pulse when a requested move is rejected
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_move_ctrl
  import maze_parameters::*;
#(
  parameter int MAZE_W  = maze_parameters::MAZE_W,
  parameter int MAZE_H  = maze_parameters::MAZE_H,
  parameter int COORD_W = maze_parameters::COORD_W,
  parameter int START_X = 1,
  parameter int START_Y = 0,
  parameter int END_X   = 8,
  parameter int END_Y   = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MAZE_W*MAZE_H-1:0] maze,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   frame_start,
  input  logic                   restart,
  output logic [2*COORD_W-1:0]   player_pos,
  output logic [2*COORD_W-1:0]   player_end,
  output logic                   win,
  output logic [15:0]            move_count,
  output logic                   bump
);

  localparam int                 c_IDX_W   = $clog2(MAZE_W * MAZE_H);
  localparam logic [COORD_W-1:0] c_START_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] c_START_Y = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] c_END_X   = COORD_W'(END_X);
  localparam logic [COORD_W-1:0] c_END_Y   = COORD_W'(END_Y);

  state_t               r_state;
  dir_t                 r_dir;
  logic [COORD_W-1:0]   r_pos_x;
  logic [COORD_W-1:0]   r_pos_y;
  logic [COORD_W-1:0]   r_tgt_x;
  logic [COORD_W-1:0]   r_tgt_y;
  logic [15:0]          r_move_count;
  logic                 r_win;
  logic                 r_bump;

  logic [3:0]           w_edge;
  logic [COORD_W-1:0]   w_tx;
  logic [COORD_W-1:0]   w_ty;
  logic                 w_oob;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_blocked;

  // Bit order matches the direction encoding, so index 0 is up.
  btn_edge_detect #(
    .WIDTH (4)
  ) u_btn_edge (
    .clk      (clk),
    .reset    (reset),
    .btn      ({btn_right, btn_left, btn_down, btn_up}),
    .btn_edge (w_edge)
  );

  // Target cell and legality. Bounds are tested before the arithmetic is
  // trusted, so a wrapped coordinate is never used as a maze index.
  always_comb begin
    w_tx  = r_pos_x;
    w_ty  = r_pos_y;
    w_oob = 1'b0;
    case (r_dir)
      DIR_UP: begin
        w_oob = (r_pos_y == '0);
        w_ty  = r_pos_y - 1'b1;
      end
      DIR_DOWN: begin
        w_oob = ((32'(r_pos_y) + 32'd1) >= 32'(MAZE_H));
        w_ty  = r_pos_y + 1'b1;
      end
      DIR_LEFT: begin
        w_oob = (r_pos_x == '0);
        w_tx  = r_pos_x - 1'b1;
      end
      DIR_RIGHT: begin
        w_oob = ((32'(r_pos_x) + 32'd1) >= 32'(MAZE_W));
        w_tx  = r_pos_x + 1'b1;
      end
      default: w_oob = 1'b1;
    endcase
    w_idx     = w_oob ? '0 : c_IDX_W'(32'(w_ty) * 32'(MAZE_W) + 32'(w_tx));
    w_blocked = w_oob | maze[w_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_dir        <= DIR_UP;
      r_pos_x      <= c_START_X;
      r_pos_y      <= c_START_Y;
      r_tgt_x      <= c_START_X;
      r_tgt_y      <= c_START_Y;
      r_move_count <= '0;
      r_win        <= 1'b0;
      r_bump       <= 1'b0;
    end else begin
      r_bump <= 1'b0;
      if (restart) begin
        // Restart outranks any frame or button activity in the same cycle.
        r_state      <= ST_IDLE;
        r_pos_x      <= c_START_X;
        r_pos_y      <= c_START_Y;
        r_move_count <= '0;
        r_win        <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (|w_edge) begin
              r_dir   <= pick_dir(w_edge);
              r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (w_blocked) begin
              r_bump  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_tgt_x <= w_tx;
              r_tgt_y <= w_ty;
              r_state <= ST_WAIT_FRAME;
            end
          end
          ST_WAIT_FRAME: begin
            if (frame_start) begin
              r_pos_x <= r_tgt_x;
              r_pos_y <= r_tgt_y;
              if (r_move_count != 16'hFFFF) begin
                r_move_count <= r_move_count + 16'd1;
              end
              if ((r_tgt_x == c_END_X) && (r_tgt_y == c_END_Y)) begin
                r_win   <= 1'b1;
                r_state <= ST_WIN;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_WIN: begin
            r_state <= ST_WIN;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign player_pos = {r_pos_x, r_pos_y};
  assign player_end = {c_END_X, c_END_Y};
  assign win        = r_win;
  assign move_count = r_move_count;
  assign bump       = r_bump;

endmodule

`default_nettype wire

// File: tb/tb_maze_move_ctrl.sv
// ============================================================================
// Module   : tb_maze_move_ctrl
// Purpose  : Directed self-checking bench for maze_move_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_move_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [99:0]  maze;
  logic [3:0]   btns;   // {right, left, down, up}
  logic         frame_start;
  logic         restart;
  logic [7:0]   player_pos;
  logic [7:0]   player_end;
  logic         win;
  logic [15:0]  move_count;
  logic         bump;

  int n_vec = 0;
  int n_err = 0;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  always #5 clk = ~clk;

  maze_move_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .maze        (maze),
    .btn_up      (btns[0]),
    .btn_down    (btns[1]),
    .btn_left    (btns[2]),
    .btn_right   (btns[3]),
    .frame_start (frame_start),
    .restart     (restart),
    .player_pos  (player_pos),
    .player_end  (player_end),
    .win         (win),
    .move_count  (move_count),
    .bump        (bump)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press one button for a cycle, let CHECK resolve, then deliver a frame.
  task automatic move(input int d);
    btns[d] = 1'b1;
    step();
    btns = '0;
    step();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    maze        = '0;
    maze[10]    = 1'b1;          // wall at (0,1)
    btns        = '0;
    frame_start = 1'b0;
    restart     = 1'b0;

    // Reset values
    #12;
    check("rst_pos",   32'(player_pos), 32'h10);
    check("rst_cnt",   32'(move_count), 32'd0);
    check("rst_win",   32'(win),        32'd0);
    check("rst_bump",  32'(bump),       32'd0);
    check("end_pos",   32'(player_end), 32'h89);
    step();
    reset = 1'b1;
    step();

    // Up from (1,0): out of bounds, no wrap
    btns[UP] = 1'b1; step(); btns = '0; step();
    check("up_oob_bump",  32'(bump), 32'd1);
    step();
    check("up_oob_bump1", 32'(bump), 32'd0);
    check("up_oob_pos",   32'(player_pos), 32'h10);

    // Down to open (1,1); commit waits for frame
    btns[DOWN] = 1'b1; step(); btns = '0; step();
    check("down_bump", 32'(bump), 32'd0);
    step(); step();
    check("down_prefr", 32'(player_pos), 32'h10);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("down_pos", 32'(player_pos), 32'h11);
    check("down_cnt", 32'(move_count), 32'd1);

    // Left into wall at (0,1)
    btns[LEFT] = 1'b1; step(); btns = '0; step();
    check("wall_bump", 32'(bump), 32'd1);
    step();
    check("wall_bump1", 32'(bump), 32'd0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("wall_pos", 32'(player_pos), 32'h11);
    check("wall_cnt", 32'(move_count), 32'd1);

    // Up and right together: up wins -> (1,0)
    btns = 4'b1001; step(); btns = '0; step(); step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("prio_pos", 32'(player_pos), 32'h10);
    check("prio_cnt", 32'(move_count), 32'd2);

    // Frame during CHECK cycle is missed
    btns[RIGHT] = 1'b1; step(); btns = '0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("miss_pos", 32'(player_pos), 32'h10);
    step(); step();
    check("miss_pos2", 32'(player_pos), 32'h10);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("miss_pos3", 32'(player_pos), 32'h20);
    check("miss_cnt",  32'(move_count), 32'd3);

    // Maze change during WAIT_FRAME does not revoke the move to (2,1)
    btns[DOWN] = 1'b1; step(); btns = '0; step();
    maze[12] = 1'b1;
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    maze[12] = 1'b0;
    check("late_wall_pos", 32'(player_pos), 32'h21);
    check("late_wall_cnt", 32'(move_count), 32'd4);

    // Walk to (8,8)
    for (int i = 0; i < 6; i++) move(RIGHT);
    for (int i = 0; i < 7; i++) move(DOWN);
    check("walk_pos", 32'(player_pos), 32'h88);
    check("walk_cnt", 32'(move_count), 32'd17);
    check("walk_win", 32'(win),        32'd0);

    // Goal commit
    move(DOWN);
    check("goal_pos", 32'(player_pos), 32'h89);
    check("goal_win", 32'(win),        32'd1);
    check("goal_cnt", 32'(move_count), 32'd18);

    // Frozen in WIN
    btns[LEFT] = 1'b1; step(); btns = '0; step();
    check("win_bump", 32'(bump), 32'd0);
    move(UP);
    check("win_pos", 32'(player_pos), 32'h89);
    check("win_cnt", 32'(move_count), 32'd18);
    check("win_hold", 32'(win),       32'd1);

    // Restart from WIN
    restart = 1'b1; step(); restart = 1'b0;
    check("rs_pos", 32'(player_pos), 32'h10);
    check("rs_cnt", 32'(move_count), 32'd0);
    check("rs_win", 32'(win),        32'd0);

    // Restart colliding with frame_start in WAIT_FRAME
    btns[DOWN] = 1'b1; step(); btns = '0; step(); step();
    restart = 1'b1; frame_start = 1'b1; step();
    restart = 1'b0; frame_start = 1'b0;
    check("coll_pos", 32'(player_pos), 32'h10);
    check("coll_cnt", 32'(move_count), 32'd0);
    check("coll_win", 32'(win),        32'd0);
    // A frame now must not commit anything (pending move abandoned)
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("coll_nocommit", 32'(player_pos), 32'h10);
    // FSM back in IDLE: a fresh move works with normal latency
    move(DOWN);
    check("coll_idle_pos", 32'(player_pos), 32'h11);
    check("coll_idle_cnt", 32'(move_count), 32'd1);

    // Button held through reset
    #3;
    btns[RIGHT] = 1'b1;
    reset = 1'b0;
    step(); step();
    check("held_rst_pos", 32'(player_pos), 32'h10);
    reset = 1'b1;
    step(); step(); step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("held_bump", 32'(bump),       32'd0);
    check("held_pos",  32'(player_pos), 32'h10);
    check("held_cnt",  32'(move_count), 32'd0);
    btns = '0; step();
    move(RIGHT);
    check("repress_pos", 32'(player_pos), 32'h20);
    check("repress_cnt", 32'(move_count), 32'd1);

    // Asynchronous reset during WAIT_FRAME
    btns[DOWN] = 1'b1; step(); btns = '0; step();
    #2;
    reset = 1'b0;
    #1;
    check("async_pos", 32'(player_pos), 32'h10);
    check("async_cnt", 32'(move_count), 32'd0);
    check("async_win", 32'(win),        32'd0);
    step();
    reset = 1'b1;
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("async_abandon", 32'(player_pos), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
